uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 130 +++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Byte write port into the UART transmit FIFO (ready/valid handshake).
//   A byte is transferred on a rising clock edge where data_in_valid and
//   data_in_ready are both high.
// Signals:
//   data_in        8  byte to transmit (driven by the producer)
//   data_in_valid  1  data_in holds a byte this cycle (driven by the producer)
//   data_in_ready  1  FIFO can take a byte this cycle (driven by the FIFO)
// Modports:
//   master  producer side (CPU MMIO / testbench)
//   slave   FIFO side (uart_tx_fifo)
interface uart_tx_fifo_if;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_in_ready;

   modport master (output data_in, output data_in_valid, input data_in_ready);
   modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes written through the host port are
//   queued in a FIFO and serialized LSB first at CLOCK_FREQ/BAUD_RATE clocks
//   per bit. Back-to-back queued bytes are sent with no idle gap.
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   rst         in   synchronous active-high reset; aborts any frame and
//                    flushes the FIFO
//   host        slave modport of uart_tx_fifo_if (data_in / valid / ready)
//   serial_out  out  registered UART line, idles high
//   tx_busy     out  a frame is in progress or bytes are still queued
//   fifo_count  out  bytes waiting in the FIFO (not counting the one being sent)
module uart_tx_fifo #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_fifo_if.slave                 host,
   output logic                          serial_out,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(SYMBOL_EDGE_TIME - 1);
   localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_nxt;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift;
   logic             line_nxt;
   logic             full, empty, push, pop, bit_done;

   assign full     = (fifo_count == FULL_CNT);
   assign empty    = (fifo_count == '0);
   assign bit_done = (clk_cnt == LAST_TICK);

   // Refusing while full holds even when a pop happens in the same cycle.
   assign host.data_in_ready = !full && !rst;
   assign push               = host.data_in_valid && host.data_in_ready;
   assign tx_busy            = (state != IDLE) || !empty;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!empty) state_nxt = START;
         START:   if (bit_done) state_nxt = DATA;
         DATA:    if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
         STOP:    if (bit_done) state_nxt = empty ? IDLE : START;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / control decode. The line value is computed for the state we are
   // entering so serial_out can be a plain register that changes on the same
   // edge as the state.
   always_comb begin
      pop         = 1'b0;
      bit_idx_nxt = bit_idx;
      line_nxt    = 1'b1;
      case (state)
         IDLE:    pop = !empty;
         START:   if (bit_done) bit_idx_nxt = 3'd0;
         DATA:    if (bit_done) bit_idx_nxt = bit_idx + 3'd1;
         STOP:    pop = bit_done && !empty;
         default: pop = 1'b0;
      endcase
      case (state_nxt)
         START:   line_nxt = 1'b0;
         DATA:    line_nxt = shift[bit_idx_nxt];
         default: line_nxt = 1'b1;
      endcase
   end

   // Control registers: pointers, occupancy, bit timing, line
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         serial_out <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         // The counter restarts at every bit boundary and at the start of
         // each frame, and rests at zero while idle.
         if ((state_nxt == IDLE) || pop || bit_done) begin
            clk_cnt <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
         bit_idx    <= bit_idx_nxt;
         serial_out <= line_nxt;
      end
   end

   // Data storage, no reset needed. A push never targets the head slot being
   // popped because pushes are refused when full.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host.data_in;
      if (pop)  shift       <= mem[rd_ptr];
   end

endmodule
